stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//  Single-clock, parametrised stopwatch/timer engine with count-up and countdown modes and an optional lap FIFO.
//  Receives the 100 Hz tick as a clock-enable pulse and debounced button levels.
//  Outputs BCD time fields to the display driver.
//  Supersedes the divided-clock stopwatch logic: everything runs on clk; no derived clocks.
// PARAMETERS
//  HOUR_MAX   23  highest hour value (BCD 00..HOUR_MAX, max 99); hours wrap to 00 above it
//  LAP_DEPTH  4   lap FIFO entries (power of 2, >=2); used only with STOPWATCH_LAP_EN
//  LAP_AW     2   log2(LAP_DEPTH)
// PORTS
//  clk        in   1   system clock, 100 MHz
//  rst_n      in   1   asynchronous active-low reset
//  tick       in   1   1-cycle pulse at 100 Hz (one centisecond)
//  clr_btn    in   1   debounced clear level
//  start_btn  in   1   debounced start level
//  stop_btn   in   1   debounced stop level
//  min_btn    in   1   debounced minute-increment level
//  hour_btn   in   1   debounced hour-increment level
//  lap_btn    in   1   debounced lap-capture level
//  cd_mode    in   1   1 = countdown, 0 = count-up
//  lap_rd     in   1   pop lap FIFO head, one entry per high cycle
//  hours/minutes/seconds/centisec  out  8 each  packed BCD {tens,units}
//  running    out  1   state==RUN
//  expired    out  1   state==EXPIRED
//  lap_data   out  32  FIFO head {hours,minutes,seconds,centisec}; 0 when empty
//  lap_valid  out  1   FIFO not empty
//  lap_count  out  LAP_AW+1  entries held
//  lap_ovf    out  1   sticky: lap captured while FIFO full
// BEHAVIOUR
//  Reset: all outputs and state 0, state IDLE.
//  Button inputs: each is registered once; a rising-edge pulse is generated; the action occurs on the following edge.
//  Button input rising to visible effect = 2 clk.
//  Same-cycle button priority: clr > stop > start > hour/min > lap.
//  FSM states: IDLE, RUN, PAUSE, EXPIRED.
//   IDLE/PAUSE --start--> RUN; cd_mode is latched at this transition.
//   Start in countdown with time 00:00:00.00: ignored, state stays.
//   RUN --stop--> PAUSE.
//   RUN, countdown, decrement reaches 00:00:00.00 --> EXPIRED; running=0, expired=1.
//   Any state --clr--> IDLE: time=0, FIFO flushed, lap_ovf=0.
//   EXPIRED: only clr leaves it; start, stop and inc are ignored.
//  Counting (RUN, on tick, update 1 clk after tick):
//   Up: centisec 99->00 carries to sec; sec 59->00 to min; min 59->00 to hours.
//   Up: HOUR_MAX:59:59.99 -> 00:00:00.00, continues running.
//   Down: borrow chain is the mirror of the carry chain; 00 of a field borrows and that field reloads 99/59/59.
//  cd_mode changes while in RUN have no effect until the next start.
//  min/hour increment: only in IDLE or PAUSE, ignored in RUN.
//   min: minutes+1, 59->00, no carry into hours. hour: hours+1, HOUR_MAX->00.
//   An increment coinciding with tick in PAUSE/IDLE is applied (tick is ignored outside RUN).
//  All fields stay valid BCD; units digit never exceeds 9.
//  Lap FIFO: lap edge in RUN pushes the current registered time; laps in other states are ignored.
//   First-word-fall-through; lap_data is valid whenever lap_valid=1.
//   lap_rd when empty: no effect.
//   Push when full: entry dropped, lap_ovf=1.
//   Push+pop same cycle when full: both occur, no overflow.
//   lap_count updates 1 clk after the push/pop.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: lap FIFO, lap_btn/lap_rd logic and lap outputs are built.
//  STOPWATCH_LAP_EN undefined: no FIFO storage; lap_btn and lap_rd are ignored.
//   Without it, lap_data/lap_valid/lap_count/lap_ovf are tied 0 and all other behaviour is identical.
// TESTING
//  Up-count wrap: preset HOUR_MAX=23, 23:59:59.98, start, 2 ticks -> 00:00:00.00, running=1.
//  Countdown: min_btn x1 (00:01:00.00), cd_mode=1, start, 6000 ticks.
//   -> 00:00:00.00, expired=1; extra ticks leave it unchanged; clr -> IDLE, all 0.
//  Latency: start_btn rises at cycle n -> running=1 at n+2; clr+start same cycle -> IDLE, time 0.
//  Increment guard: RUN, min_btn/hour_btn pulses -> minutes/hours unchanged; PAUSE at min 59, min_btn -> 00, hours unchanged.
//  Lap FIFO (LAP_EN, DEPTH 4): 5 lap presses in RUN -> lap_count=4, lap_ovf=1, lap_data=first lap.
//   4 lap_rd cycles -> laps in order, then lap_valid=0.
//  Countdown start at zero -> state stays IDLE, running=0; build without LAP_EN -> lap outputs 0 under lap stimulus.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch/timer engine: BCD count-up/countdown on a 100 Hz tick enable,
// with button edge detection and an optional lap FIFO (STOPWATCH_LAP_EN).
// Ports: clk, rst_n, tick, *_btn levels, cd_mode, lap_rd in;
//        hours/minutes/seconds/centisec, running, expired, lap_* out.
module stopwatch_core #(
  parameter int HOUR_MAX  = 23,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            clr_btn,
  input  logic            start_btn,
  input  logic            stop_btn,
  input  logic            min_btn,
  input  logic            hour_btn,
  input  logic            lap_btn,
  input  logic            cd_mode,
  input  logic            lap_rd,
  output logic [7:0]      hours,
  output logic [7:0]      minutes,
  output logic [7:0]      seconds,
  output logic [7:0]      centisec,
  output logic            running,
  output logic            expired,
  output logic [31:0]     lap_data,
  output logic            lap_valid,
  output logic [LAP_AW:0] lap_count,
  output logic            lap_ovf
);

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, EXPIRED
  } state_t;

  localparam logic [7:0] HMAX =
    8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v, input logic [7:0] mx);
    logic [7:0] r;
    if (v == mx) r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v, input logic [7:0] mx);
    logic [7:0] r;
    if (v == 8'h00) r = mx;
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  state_t     state;
  logic       cd_lat;
  logic [5:0] btn_q, btn_d, pulse;
  logic       e_clr, e_stop, e_start, e_min, e_hour, e_lap;

  // Bit order {lap,hour,min,start,stop,clr}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '0;
      btn_d <= '0;
    end else begin
      btn_q <= {lap_btn, hour_btn, min_btn,
                start_btn, stop_btn, clr_btn};
      btn_d <= btn_q;
    end
  end

  assign pulse   = btn_q & ~btn_d;
  assign e_clr   = pulse[0];
  assign e_stop  = pulse[1];
  assign e_start = pulse[2];
  assign e_min   = pulse[3];
  assign e_hour  = pulse[4];
  assign e_lap   = pulse[5];

  logic [7:0] cs_u, s_u, m_u, h_u;
  logic [7:0] cs_d, s_d, m_d, h_d;
  logic       c_cs, c_s, c_m, b_cs, b_s, b_m;
  logic       dn_zero, now_zero;

  always_comb begin
    c_cs = (centisec == 8'h99);
    c_s  = c_cs && (seconds == 8'h59);
    c_m  = c_s && (minutes == 8'h59);
    cs_u = bcd_inc(centisec, 8'h99);
    s_u  = c_cs ? bcd_inc(seconds, 8'h59) : seconds;
    m_u  = c_s ? bcd_inc(minutes, 8'h59) : minutes;
    h_u  = c_m ? bcd_inc(hours, HMAX) : hours;
    b_cs = (centisec == 8'h00);
    b_s  = b_cs && (seconds == 8'h00);
    b_m  = b_s && (minutes == 8'h00);
    cs_d = bcd_dec(centisec, 8'h99);
    s_d  = b_cs ? bcd_dec(seconds, 8'h59) : seconds;
    m_d  = b_s ? bcd_dec(minutes, 8'h59) : minutes;
    h_d  = b_m ? bcd_dec(hours, HMAX) : hours;
    dn_zero  = ({h_d, m_d, s_d, cs_d} == 32'h0);
    now_zero = ({hours, minutes, seconds, centisec} == 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cd_lat   <= 1'b0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      centisec <= '0;
    end else if (e_clr) begin
      state    <= IDLE;
      cd_lat   <= 1'b0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      centisec <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (e_stop) begin
            state <= PAUSE;
          end else if (tick) begin
            if (cd_lat) begin
              {hours, minutes, seconds, centisec}
                <= {h_d, m_d, s_d, cs_d};
              if (dn_zero) state <= EXPIRED;
            end else begin
              {hours, minutes, seconds, centisec}
                <= {h_u, m_u, s_u, cs_u};
            end
          end
        end
        IDLE, PAUSE: begin
          // A stop edge outranks start even though it does nothing here
          if (e_stop) begin
            state <= state;
          end else if (e_start) begin
            if (!(cd_mode && now_zero)) begin
              state  <= RUN;
              cd_lat <= cd_mode;
            end
          end else begin
            if (e_hour) hours <= bcd_inc(hours, HMAX);
            if (e_min) minutes <= bcd_inc(minutes, 8'h59);
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

`ifdef STOPWATCH_LAP_EN
  localparam logic [LAP_AW:0] FULL = (LAP_AW+1)'(LAP_DEPTH);

  logic [31:0]       mem [LAP_DEPTH];
  logic [LAP_AW-1:0] wr_ptr, rd_ptr;
  logic              push_req, full, pop, push;

  // Lap is the lowest-priority button: any other edge masks it
  assign push_req = e_lap && (state == RUN) &&
                    !(e_clr | e_stop | e_start | e_hour | e_min);
  assign full     = (lap_count == FULL);
  assign pop      = lap_rd && (lap_count != '0);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
    end else if (e_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {hours, minutes, seconds, centisec};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) lap_count <= lap_count + 1'b1;
      else if (pop && !push) lap_count <= lap_count - 1'b1;
      if (push_req && full && !pop) lap_ovf <= 1'b1;
    end
  end

  assign lap_valid = (lap_count != '0);
  assign lap_data  = lap_valid ? mem[rd_ptr] : 32'h0;
`else
  logic unused_lap;
  assign unused_lap = ^{e_lap, lap_rd, LAP_DEPTH[0]};
  assign lap_data   = 32'h0;
  assign lap_valid  = 1'b0;
  assign lap_count  = '0;
  assign lap_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core.
// Covers latency, carry/borrow, wrap, inc guard, lap FIFO.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        cd_mode = 1'b0;
  logic        lap_rd = 1'b0;
  logic [5:0]  btns = '0;
  logic [7:0]  hours, minutes, seconds, centisec;
  logic        running, expired, lap_valid, lap_ovf;
  logic [31:0] lap_data;
  logic [2:0]  lap_count;
  logic [31:0] tw;

  int errors = 0;
  int checks = 0;

  localparam int CLR = 0, STOP = 1, START = 2;
  localparam int MIN = 3, HOUR = 4, LAP = 5;

  stopwatch_core #(
    .HOUR_MAX(23), .LAP_DEPTH(4), .LAP_AW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .clr_btn(btns[0]), .stop_btn(btns[1]),
    .start_btn(btns[2]), .min_btn(btns[3]),
    .hour_btn(btns[4]), .lap_btn(btns[5]),
    .cd_mode(cd_mode), .lap_rd(lap_rd),
    .hours(hours), .minutes(minutes),
    .seconds(seconds), .centisec(centisec),
    .running(running), .expired(expired),
    .lap_data(lap_data), .lap_valid(lap_valid),
    .lap_count(lap_count), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  assign tw = {hours, minutes, seconds, centisec};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    step(1);
    btns[b] = 1'b0;
    step(1);
  endtask

  task automatic presses(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    chk("rst_time", tw, 32'h0);
    chk("rst_run", {31'b0, running}, 32'h0);
    chk("rst_exp", {31'b0, expired}, 32'h0);
    chk("rst_lapv", {31'b0, lap_valid}, 32'h0);
    chk("rst_lapc", {29'b0, lap_count}, 32'h0);
    chk("rst_lapd", lap_data, 32'h0);
    rst_n = 1'b1;
    step(2);

    // start latency: visible two edges after the rise
    btns[START] = 1'b1;
    step(1);
    chk("lat_n1", {31'b0, running}, 32'h0);
    btns[START] = 1'b0;
    step(1);
    chk("lat_n2", {31'b0, running}, 32'h1);
    ticks(3);
    chk("up_3", tw, 32'h00000003);
    ticks(97);
    chk("up_carry", tw, 32'h00000100);
    press(MIN);
    press(HOUR);
    chk("inc_in_run", tw, 32'h00000100);
    press(STOP);
    chk("stop_run", {31'b0, running}, 32'h0);
    ticks(5);
    chk("pause_hold", tw, 32'h00000100);
    press(CLR);
    chk("clr_time", tw, 32'h0);

    // clr and start together: clr wins
    btns[CLR] = 1'b1;
    btns[START] = 1'b1;
    step(1);
    btns = '0;
    step(1);
    chk("clrstart_run", {31'b0, running}, 32'h0);
    chk("clrstart_t", tw, 32'h0);

    // countdown start at zero ignored
    cd_mode = 1'b1;
    press(START);
    chk("cd0_run", {31'b0, running}, 32'h0);
    chk("cd0_exp", {31'b0, expired}, 32'h0);
    cd_mode = 1'b0;

    presses(MIN, 58);
    chk("min58", tw, 32'h00580000);
    press(START);
    press(STOP);
    chk("paused", {31'b0, running}, 32'h0);
    press(MIN);
    chk("min59", tw, 32'h00590000);
    press(MIN);
    chk("min_wrap", tw, 32'h00000000);
    presses(MIN, 59);
    tick = 1'b1;
    press(HOUR);
    tick = 1'b0;
    chk("hour_tick", tw, 32'h01590000);
    presses(HOUR, 22);
    chk("hour23", tw, 32'h23590000);
    press(HOUR);
    chk("hour_wrap", tw, 32'h00590000);
    presses(HOUR, 23);

    // up-count full wrap
    press(START);
    ticks(5998);
    chk("pre_wrap", tw, 32'h23595998);
    ticks(2);
    chk("wrap_time", tw, 32'h00000000);
    chk("wrap_run", {31'b0, running}, 32'h1);
    ticks(1);
    chk("post_wrap", tw, 32'h00000001);

    // lap captures at 01,02,03,04; fifth (05) overflows
    for (int i = 0; i < 5; i++) begin
      press(LAP);
      ticks(1);
    end
`ifdef STOPWATCH_LAP_EN
    chk("lap_cnt", {29'b0, lap_count}, 32'h4);
    chk("lap_ovf", {31'b0, lap_ovf}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("lap_head", lap_data, 32'(i));
      chk("lap_v", {31'b0, lap_valid}, 32'h1);
      lap_rd = 1'b1;
      step(1);
      lap_rd = 1'b0;
    end
    chk("lap_empty", {31'b0, lap_valid}, 32'h0);
    chk("lap_d0", lap_data, 32'h0);
    lap_rd = 1'b1;
    step(1);
    lap_rd = 1'b0;
    chk("lap_rd_empty", {29'b0, lap_count}, 32'h0);
`else
    chk("nolap_cnt", {29'b0, lap_count}, 32'h0);
    chk("nolap_ovf", {31'b0, lap_ovf}, 32'h0);
    chk("nolap_v", {31'b0, lap_valid}, 32'h0);
    lap_rd = 1'b1;
    step(1);
    lap_rd = 1'b0;
    chk("nolap_d", lap_data, 32'h0);
`endif
    press(CLR);
    chk("clr_ovf", {31'b0, lap_ovf}, 32'h0);
    chk("clr_t2", tw, 32'h0);

    // countdown from one minute
    press(MIN);
    chk("cd_preset", tw, 32'h00010000);
    cd_mode = 1'b1;
    press(START);
    cd_mode = 1'b0;
    chk("cd_run", {31'b0, running}, 32'h1);
    ticks(1);
    chk("cd_borrow", tw, 32'h00005999);
    ticks(5998);
    chk("cd_last", tw, 32'h00000001);
    chk("cd_notexp", {31'b0, expired}, 32'h0);
    ticks(1);
    chk("cd_zero", tw, 32'h0);
    chk("cd_exp", {31'b0, expired}, 32'h1);
    chk("cd_run0", {31'b0, running}, 32'h0);
    ticks(10);
    press(START);
    press(MIN);
    chk("exp_hold_t", tw, 32'h0);
    chk("exp_hold", {31'b0, expired}, 32'h1);
    press(CLR);
    chk("exp_clr", {31'b0, expired}, 32'h0);
    chk("exp_clr_r", {31'b0, running}, 32'h0);
    chk("exp_clr_t", tw, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
